multicycle_control_rv32i: RTL and testbench
===========================================

Name: multicycle_control_rv32i

Overview:
- Next-generation control FSM for the multicycle RV32I core. Drives the shared-memory datapath: PC, IR/OldPC, register file, ALU, ALUOut and data register.
- Adds over the previous controller: all RV32I opcode classes, all six branch conditions, memory wait states via a req/ready handshake, an illegal-instruction halt, and cycle/retired-instruction counters.
- The ALU function decoder and the immediate extender stay external. This block emits alu_op and ImmSrc only.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt; both wrap modulo 2^CNT_W.
- TRAP_ILLEGAL, 1, 1: illegal/SYSTEM opcode enters HALT; 0: treated as NOP, returns to FETCH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- instr  in  32  IR contents; opcode=[6:0], funct3=[14:12]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1<rs2 (valid in BRANCH)
- ltu  in  1  unsigned rs1<rs2 (valid in BRANCH)
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC load enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1, 11=zero
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=imm, 10=const 4
- alu_op  out  2  ALU operation class: 00=add, 01=branch compare, 10=funct-decoded
- ImmSrc  out  3  immediate format: I=000, S=001, B=010, U=011, J=100
- RegWrite  out  1  register file write enable
- halted  out  1  FSM is in HALT
- state_dbg  out  4  current state encoding
- cycle_cnt  out  CNT_W  cycles since reset, frozen while halted
- instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (rst low, asynchronous):
  - state=FETCH, counters=0, halted=0.
  - All control outputs are forced 0 while rst is low.
- Outputs are combinational from state (Moore), except:
  - the FETCH/MEMREAD/MEMWRITE commit strobes, which are gated by mem_ready;
  - PCWrite in BRANCH, which depends on the flags.
- Any output not listed for a state is 0.
- ImmSrc is a pure function of opcode in every state:
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - other: 000
- States and transitions:
  - FETCH: mem_req=1, AdrSrc=0. Holds while mem_ready=0. On mem_ready=1, in the same cycle: IRWrite=1, PCWrite=1, A=00, B=10, ResultSrc=10, alu_op=00; next state DECODE.
  - DECODE: A=01, B=01, alu_op=00 (computes target into ALUOut). Next state by opcode:
    - load/store → MEMADR
    - R-type → EXECR
    - I-ALU → EXECI
    - branch → BRANCH
    - JAL → JAL
    - JALR → JALR
    - LUI → LUI
    - AUIPC → ALUWB
    - FENCE (0001111) → FETCH
    - SYSTEM or undefined opcode → HALT if TRAP_ILLEGAL=1, else FETCH
  - MEMADR: A=10, B=01, alu_op=00. Next: load → MEMREAD, store → MEMWRITE.
  - MEMREAD: mem_req=1, AdrSrc=1. Holds until mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
  - MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. Holds until mem_ready, then FETCH. MemWrite stays asserted throughout the wait.
  - EXECR: A=10, B=00, alu_op=10. Next ALUWB.
  - EXECI: A=10, B=01, alu_op=10. Next ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
  - BRANCH: A=10, B=00, alu_op=01, ResultSrc=00. PCWrite=taken, where taken by funct3 is:
    - 000: zero
    - 001: !zero
    - 100: lt
    - 101: !lt
    - 110: ltu
    - 111: !ltu
    - 010/011: 0
    Next FETCH.
  - JALR: A=10, B=01, alu_op=00 (rs1+imm into ALUOut). Next JAL. Clearing target bit 0 is a datapath function.
  - JAL: A=01, B=10, alu_op=00, ResultSrc=00, PCWrite=1 (PC←ALUOut target; ALU computes OldPC+4). Next ALUWB.
  - LUI: A=11, B=01, alu_op=00. Next ALUWB.
  - HALT: halted=1, all strobes 0. Exited only by reset.
- Latency with mem_ready tied 1, in cycles:
  - AUIPC: 3
  - branch: 3
  - R/I-ALU: 4
  - store: 4
  - LUI: 4
  - JAL: 4
  - load: 5
  - JALR: 5
  - Each low mem_ready cycle adds exactly one cycle.
- Counters:
  - cycle_cnt increments every cycle when not in HALT.
  - instret_cnt increments on every transition into FETCH from a non-FETCH state, including a FENCE/NOP. Entry to HALT does not count.
- Unknown state encodings go to FETCH on the next clock.
- Reset asserted mid-access (e.g. in MEMWRITE): all outputs drop 0 immediately; the access is abandoned, not replayed.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 → FETCH,DECODE,EXECR,ALUWB. EXECR: A=10, B=00, alu_op=10. ALUWB: RegWrite=1. instret_cnt 0→1 after 4 cycles.
- lw x5,8(x1) (0x0080A283), mem_ready low 2 cycles in MEMREAD → MEMREAD lasts 3 cycles with mem_req=1, AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1. Total 7 cycles.
- sw x5,8(x1) (0x0050A423), ImmSrc=001 → MEMWRITE: MemWrite=1 held until mem_ready; RegWrite never 1.
- bne x1,x2,8 (0x00209463): zero=1 → PCWrite=0 in BRANCH; repeat with zero=0 → PCWrite=1. Also blt (funct3=100) with lt=1 → PCWrite=1.
- jalr x1,0(x2) (0x000100E7) → DECODE,JALR,JAL,ALUWB. JAL: PCWrite=1, ResultSrc=00. ALUWB: RegWrite=1.
- ecall (0x00000073), TRAP_ILLEGAL=1 → HALT, halted=1, cycle_cnt frozen. Async rst low → state_dbg=FETCH, counters 0.

Source files
------------

// File: rtl/multicycle_control_rv32i_if.sv
// multicycle_control_rv32i_if: memory handshake and datapath control bundle between controller and datapath
interface multicycle_control_rv32i_if;
  logic [31:0] instr;
  logic zero, lt, ltu, mem_ready;
  logic mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, alu_op;
  logic [2:0] ImmSrc;
  modport master (
    input  instr, zero, lt, ltu, mem_ready,
    output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, alu_op, ImmSrc
  );
  modport slave (
    output instr, zero, lt, ltu, mem_ready,
    input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, alu_op, ImmSrc
  );
endinterface

// File: rtl/multicycle_control_rv32i.sv
// multicycle_control_rv32i: Moore control FSM for the shared-memory multicycle RV32I datapath
module multicycle_control_rv32i #(
  parameter int CNT_W = 32,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_rv32i_if.master bus,
  output logic halted,
  output logic [3:0] state_dbg,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_HALT
  } state_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_FENCE = 7'b0001111;
  state_t state, state_nx;
  logic [6:0] op;
  logic [2:0] f3, imm_src;
  logic taken;
  logic mem_req, pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, src_a, src_b, alu_op;
  logic unused_instr;
  assign op = bus.instr[6:0];
  assign f3 = bus.instr[14:12];
  assign unused_instr = ^{bus.instr[31:15], bus.instr[11:7]};
  assign taken = f3 == 3'b000 ? bus.zero :
                 f3 == 3'b001 ? !bus.zero :
                 f3 == 3'b100 ? bus.lt :
                 f3 == 3'b101 ? !bus.lt :
                 f3 == 3'b110 ? bus.ltu :
                 f3 == 3'b111 ? !bus.ltu : 1'b0;
  assign imm_src = (op == OP_I || op == OP_LOAD || op == OP_JALR) ? 3'b000 :
                   op == OP_STORE ? 3'b001 :
                   op == OP_BR ? 3'b010 :
                   (op == OP_LUI || op == OP_AUIPC) ? 3'b011 :
                   op == OP_JAL ? 3'b100 : 3'b000;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_FETCH;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cycle_cnt <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state != S_FETCH && state_nx == S_FETCH) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:    state_nx = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (op)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R:              state_nx = S_EXECR;
          OP_I:              state_nx = S_EXECI;
          OP_BR:             state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          OP_JALR:           state_nx = S_JALR;
          OP_LUI:            state_nx = S_LUI;
          OP_AUIPC:          state_nx = S_ALUWB;
          OP_FENCE:          state_nx = S_FETCH;
          default:           state_nx = TRAP_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      S_MEMADR:   state_nx = op == OP_STORE ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nx = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_nx = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_nx = S_ALUWB;
      S_EXECI:    state_nx = S_ALUWB;
      S_JALR:     state_nx = S_JAL;
      S_JAL:      state_nx = S_ALUWB;
      S_LUI:      state_nx = S_ALUWB;
      S_HALT:     state_nx = S_HALT;
      default:    state_nx = S_FETCH;
    endcase
  end
  always_comb begin
    mem_req = 1'b0;
    pc_write = 1'b0;
    adr_src = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    result_src = 2'b00;
    src_a = 2'b00;
    src_b = 2'b00;
    alu_op = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_write = bus.mem_ready;
        pc_write = bus.mem_ready;
        src_b = bus.mem_ready ? 2'b10 : 2'b00;
        result_src = bus.mem_ready ? 2'b10 : 2'b00;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
      end
      S_MEMADR, S_JALR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a = 2'b10;
        alu_op = 2'b10;
      end
      S_EXECI: begin
        src_a = 2'b10;
        src_b = 2'b01;
        alu_op = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        src_a = 2'b10;
        alu_op = 2'b01;
        pc_write = taken;
      end
      S_JAL: begin
        src_a = 2'b01;
        src_b = 2'b10;
        pc_write = 1'b1;
      end
      S_LUI: begin
        src_a = 2'b11;
        src_b = 2'b01;
      end
      default: ;
    endcase
  end
  // Every strobe is held low combinationally while reset is asserted, abandoning any access in flight
  assign bus.mem_req = rst & mem_req;
  assign bus.PCWrite = rst & pc_write;
  assign bus.AdrSrc = rst & adr_src;
  assign bus.MemWrite = rst & mem_write;
  assign bus.IRWrite = rst & ir_write;
  assign bus.RegWrite = rst & reg_write;
  assign bus.ResultSrc = rst ? result_src : 2'b00;
  assign bus.ALUSrcA = rst ? src_a : 2'b00;
  assign bus.ALUSrcB = rst ? src_b : 2'b00;
  assign bus.alu_op = rst ? alu_op : 2'b00;
  assign bus.ImmSrc = rst ? imm_src : 3'b000;
  assign halted = state == S_HALT;
  assign state_dbg = state;
endmodule

// File: tb/tb_multicycle_control_rv32i.sv
// tb_multicycle_control_rv32i: scoreboard bench; per-cycle expected state/controls queued with stimulus
module tb_multicycle_control_rv32i;
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
                         S_LUI = 4'd12, S_HALT = 4'd13;
  typedef struct {
    logic rdy;
    logic [3:0] st;
    logic [16:0] ctl;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halted;
  logic [3:0] state_dbg;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [16:0] ctl_now;
  logic [2:0] imm_e;
  int checks = 0;
  int errors = 0;
  int cyc_e = 0;
  int ret_e = 0;
  exp_t exp_q[$];
  multicycle_control_rv32i_if bus();
  multicycle_control_rv32i #(.CNT_W(32), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .halted(halted), .state_dbg(state_dbg),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );
  always #5 clk = ~clk;
  assign ctl_now = {bus.mem_req, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                    bus.ALUSrcA, bus.ALUSrcB, bus.alu_op, bus.ImmSrc, bus.RegWrite};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [16:0] ctl_of(input logic [3:0] st, input logic rdy, input logic tk,
                                         input logic [2:0] imm);
    logic mr, pw, as, mw, iw, rw;
    logic [1:0] rs, a, b, op;
    {mr, pw, as, mw, iw, rw} = 6'b0;
    {rs, a, b, op} = 8'b0;
    case (st)
      S_FETCH:    begin mr = 1; iw = rdy; pw = rdy; b = rdy ? 2'b10 : 2'b00; rs = rdy ? 2'b10 : 2'b00; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:  begin mr = 1; as = 1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_MEMWRITE: begin mr = 1; as = 1; mw = 1; end
      S_EXECR:    begin a = 2'b10; op = 2'b10; end
      S_EXECI:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
      S_ALUWB:    rw = 1;
      S_BRANCH:   begin a = 2'b10; op = 2'b01; pw = tk; end
      S_JALR:     begin a = 2'b10; b = 2'b01; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pw = 1; end
      S_LUI:      begin a = 2'b11; b = 2'b01; end
      default: ;
    endcase
    return {mr, pw, as, mw, iw, rs, a, b, op, imm, rw};
  endfunction
  task automatic push(input logic [3:0] st, input logic rdy = 1'b1, input logic tk = 1'b0);
    exp_q.push_back('{rdy: rdy, st: st, ctl: ctl_of(st, rdy, tk, imm_e)});
  endtask
  task automatic load(input logic [31:0] ins, input logic [2:0] imm, input logic z = 0,
                      input logic l = 0, input logic lu = 0);
    bus.instr = ins;
    bus.zero = z;
    bus.lt = l;
    bus.ltu = lu;
    imm_e = imm;
  endtask
  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.mem_ready = e.rdy;
      #1;
      check("state", {28'b0, state_dbg}, {28'b0, e.st});
      check("ctrl", {15'b0, ctl_now}, {15'b0, e.ctl});
      check("halted", {31'b0, halted}, {31'b0, e.st == S_HALT});
      if (e.st != S_HALT) cyc_e++;
      @(negedge clk);
    end
  endtask
  task automatic retire(input string tag);
    drain();
    ret_e++;
    check({tag, "_cycle_cnt"}, cycle_cnt, cyc_e);
    check({tag, "_instret"}, instret_cnt, ret_e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    load(32'h0, 3'b000);
    bus.mem_ready = 1'b1;
    #12;
    check("rst_state", {28'b0, state_dbg}, {28'b0, S_FETCH});
    check("rst_ctrl", {15'b0, ctl_now}, 32'h0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_instret", instret_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    load(32'h002081B3, 3'b000);
    push(S_FETCH); push(S_DECODE); push(S_EXECR); push(S_ALUWB);
    retire("add");
    load(32'h0080A283, 3'b000);
    push(S_FETCH); push(S_DECODE); push(S_MEMADR);
    push(S_MEMREAD, 0); push(S_MEMREAD, 0); push(S_MEMREAD, 1); push(S_MEMWB);
    retire("lw");
    load(32'h0050A423, 3'b001);
    push(S_FETCH, 0); push(S_FETCH); push(S_DECODE); push(S_MEMADR);
    push(S_MEMWRITE, 0); push(S_MEMWRITE, 1);
    retire("sw");
    load(32'h00209463, 3'b010, 1);
    push(S_FETCH); push(S_DECODE); push(S_BRANCH, 1, 0);
    retire("bne_nt");
    load(32'h00209463, 3'b010, 0);
    push(S_FETCH); push(S_DECODE); push(S_BRANCH, 1, 1);
    retire("bne_t");
    load(32'h0020C463, 3'b010, 0, 1, 0);
    push(S_FETCH); push(S_DECODE); push(S_BRANCH, 1, 1);
    retire("blt_t");
    load(32'h0020F463, 3'b010, 0, 0, 1);
    push(S_FETCH); push(S_DECODE); push(S_BRANCH, 1, 0);
    retire("bgeu_nt");
    load(32'h0020A463, 3'b010, 1, 1, 1);
    push(S_FETCH); push(S_DECODE); push(S_BRANCH, 1, 0);
    retire("f3_010");
    load(32'h000100E7, 3'b000);
    push(S_FETCH); push(S_DECODE); push(S_JALR); push(S_JAL); push(S_ALUWB);
    retire("jalr");
    load(32'h123450B7, 3'b011);
    push(S_FETCH); push(S_DECODE); push(S_LUI); push(S_ALUWB);
    retire("lui");
    load(32'h00001097, 3'b011);
    push(S_FETCH); push(S_DECODE); push(S_ALUWB);
    retire("auipc");
    load(32'h008000EF, 3'b100);
    push(S_FETCH); push(S_DECODE); push(S_JAL); push(S_ALUWB);
    retire("jal");
    load(32'h0000000F, 3'b000);
    push(S_FETCH); push(S_DECODE);
    retire("fence");
    load(32'h00108093, 3'b000);
    push(S_FETCH); push(S_DECODE); push(S_EXECI); push(S_ALUWB);
    retire("addi");
    load(32'h00000073, 3'b000);
    push(S_FETCH); push(S_DECODE); push(S_HALT); push(S_HALT); push(S_HALT);
    drain();
    check("halt_cycle_cnt", cycle_cnt, cyc_e);
    check("halt_instret", instret_cnt, ret_e);
    rst = 1'b0;
    #1;
    check("arst_state", {28'b0, state_dbg}, {28'b0, S_FETCH});
    check("arst_halted", {31'b0, halted}, 32'h0);
    check("arst_cycle", cycle_cnt, 0);
    check("arst_instret", instret_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc_e = 0;
    ret_e = 0;
    load(32'h0050A423, 3'b001);
    push(S_FETCH); push(S_DECODE); push(S_MEMADR); push(S_MEMWRITE, 0);
    drain();
    check("mw_wait_state", {28'b0, state_dbg}, {28'b0, S_MEMWRITE});
    rst = 1'b0;
    #1;
    check("mw_abort_ctrl", {15'b0, ctl_now}, 32'h0);
    check("mw_abort_state", {28'b0, state_dbg}, {28'b0, S_FETCH});
    @(negedge clk);
    rst = 1'b1;
    cyc_e = 0;
    ret_e = 0;
    load(32'h002081B3, 3'b000);
    push(S_FETCH); push(S_DECODE); push(S_EXECR); push(S_ALUWB);
    retire("add_after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
